// File: rtl/piano_pkg.sv
// Shared types and constants for the piano playback/tone path.
package piano_pkg;

  typedef enum logic [2:0] {
    ST_MANUAL = 3'd0,
    ST_STOP   = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  localparam logic [2:0]  MODE_MANUAL = 3'b000;
  localparam logic [2:0]  MODE_SONG1  = 3'b001;
  localparam logic [2:0]  MODE_SONG2  = 3'b010;
  localparam logic [15:0] TONE_SILENT = 16'd0;
  localparam int          CLK_HZ      = 12000000;

  // Song index i plays as player mode i+1.
  function automatic logic [2:0] song_mode(input logic [2:0] idx);
    return MODE_SONG1 + idx;
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Load wins over decrement; the count saturates at zero.
module gap_timer #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/play_sequencer.sv
// Playback FSM driving Music_Player mode/enable, plus keyboard/auto tone arbiter.
// All outputs registered: inputs sampled in cycle N show up at N+1.
module play_sequencer
  import piano_pkg::*;
#(
  parameter int NUM_SONGS  = 2,
  parameter int IDX_W      = 3,
  parameter int GAP_CYCLES = CLK_HZ / 2,
  parameter int LOOP_EN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             manual_sel,
  input  logic             btn_play,
  input  logic             btn_next,
  input  logic             key_valid,
  input  logic [15:0]      key_tone,
  input  logic [15:0]      auto_tone,
  input  logic             song_finished,
  output logic [2:0]       player_mode,
  output logic             player_enable,
  output logic [15:0]      out_tone,
  output logic [IDX_W-1:0] song_idx,
  output logic [2:0]       state
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SONGS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sf_q;
  logic             sf_rise;
  logic [2:0]       mode_q;
  logic             en_q;
  logic [15:0]      tone_q;
  logic             gap_load, gap_dec, gap_expired;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .expired  (gap_expired)
  );

  assign sf_rise = song_finished & ~sf_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    if (manual_sel) begin
      state_d = ST_MANUAL;
    end else begin
      case (state_q)
        ST_MANUAL: state_d = ST_STOP;
        ST_STOP: begin
          if (btn_play)      state_d = ST_PLAY;
          else if (btn_next) idx_d   = next_idx(idx_q);
        end
        ST_PLAY: begin
          if (btn_play) begin
            state_d = ST_PAUSE;
          end else if (btn_next || sf_rise) begin
            // Natural end of the last song without looping parks at song 0.
            if (!btn_next && (LOOP_EN == 0) && (idx_q == LAST_IDX)) begin
              idx_d   = '0;
              state_d = ST_STOP;
            end else begin
              idx_d    = next_idx(idx_q);
              gap_load = 1'b1;
              state_d  = ST_GAP;
            end
          end
        end
        ST_PAUSE: begin
          if (btn_play) begin
            state_d = ST_PLAY;
          end else if (btn_next) begin
            idx_d    = next_idx(idx_q);
            gap_load = 1'b1;
            state_d  = ST_GAP;
          end
        end
        ST_GAP: begin
          if (btn_play) begin
            state_d = ST_STOP;
          end else if (btn_next) begin
            idx_d    = next_idx(idx_q);
            gap_load = 1'b1;
          end else if (gap_expired) begin
            state_d = ST_PLAY;
          end else begin
            gap_dec = 1'b1;
          end
        end
        default: state_d = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      idx_q   <= '0;
      sf_q    <= 1'b0;
      mode_q  <= MODE_MANUAL;
      en_q    <= 1'b0;
      tone_q  <= TONE_SILENT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sf_q    <= song_finished;
      // Pause keeps the song mode so the player resumes where it stopped.
      mode_q  <= ((state_d == ST_PLAY) || (state_d == ST_PAUSE)) ?
                 song_mode(3'(idx_d)) : MODE_MANUAL;
      en_q    <= (state_d == ST_PLAY);
      // Arbitration looks at the current state, so auto_tone trails entry to PLAY by a cycle.
      tone_q  <= key_valid ? key_tone :
                 ((state_q == ST_PLAY) ? auto_tone : TONE_SILENT);
    end
  end

  assign player_mode   = mode_q;
  assign player_enable = en_q;
  assign out_tone      = tone_q;
  assign song_idx      = idx_q;
  assign state         = state_q;

endmodule

// File: tb/tb_play_sequencer.sv
// Randomised scoreboard bench: two sequencers (looping and non-looping) share stimulus.
module tb_play_sequencer;

  localparam int NS  = 2;
  localparam int GAP = 4;
  localparam int S_MAN = 0, S_STOP = 1, S_PLAY = 2, S_PAUSE = 3, S_GAP = 4;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  idx;
    logic [2:0]  mode;
    logic        en;
    logic [15:0] tone;
  } obs_t;

  typedef struct packed {
    obs_t l;
    obs_t s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        manual_sel = 1'b0, btn_play = 1'b0, btn_next = 1'b0;
  logic        key_valid = 1'b0, song_finished = 1'b0;
  logic [15:0] key_tone = '0, auto_tone = '0;

  logic [2:0]  pm0, pm1, st0, st1, idx0, idx1;
  logic        en0, en1;
  logic [15:0] tone0, tone1;
  obs_t        got0, got1;

  int n_vec = 0;
  int n_err = 0;
  exp_t q[$];

  int m_st[2], m_idx[2], m_left[2];
  bit m_sfq[2];

  always #5 clk = ~clk;

  play_sequencer #(.NUM_SONGS(NS), .IDX_W(3), .GAP_CYCLES(GAP), .LOOP_EN(1)) dut_loop (
    .clk(clk), .rst_n(rst_n), .manual_sel(manual_sel), .btn_play(btn_play),
    .btn_next(btn_next), .key_valid(key_valid), .key_tone(key_tone),
    .auto_tone(auto_tone), .song_finished(song_finished),
    .player_mode(pm0), .player_enable(en0), .out_tone(tone0),
    .song_idx(idx0), .state(st0)
  );

  play_sequencer #(.NUM_SONGS(NS), .IDX_W(3), .GAP_CYCLES(GAP), .LOOP_EN(0)) dut_stop (
    .clk(clk), .rst_n(rst_n), .manual_sel(manual_sel), .btn_play(btn_play),
    .btn_next(btn_next), .key_valid(key_valid), .key_tone(key_tone),
    .auto_tone(auto_tone), .song_finished(song_finished),
    .player_mode(pm1), .player_enable(en1), .out_tone(tone1),
    .song_idx(idx1), .state(st1)
  );

  assign got0 = {st0, idx0, pm0, en0, tone0};
  assign got1 = {st1, idx1, pm1, en1, tone1};

  task automatic check_field(input string nm, input int d, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, d, act, req, $time);
    end
  endtask

  task automatic check_obs(input int d, input obs_t e, input obs_t g);
    check_field("state", d, int'(g.st), int'(e.st));
    check_field("song_idx", d, int'(g.idx), int'(e.idx));
    check_field("player_mode", d, int'(g.mode), int'(e.mode));
    check_field("player_enable", d, int'(g.en), int'(e.en));
    check_field("out_tone", d, int'(g.tone), int'(e.tone));
  endtask

  // Reference: gap tracked as "cycles of silence still to play", songs as modulo index.
  task automatic model_step(input int d, input bit ms, bp, bn, sf, kv,
                            input logic [15:0] kt, at, output obs_t o);
    int  s;
    int  i;
    bit  rise;
    bit  loop_en;
    s       = m_st[d];
    i       = m_idx[d];
    loop_en = (d == 0);
    rise    = sf && !m_sfq[d];
    o.tone  = kv ? kt : ((m_st[d] == S_PLAY) ? at : 16'd0);
    if (ms) s = S_MAN;
    else begin
      case (m_st[d])
        S_MAN:  s = S_STOP;
        S_STOP: if (bp) s = S_PLAY; else if (bn) i = (i + 1) % NS;
        S_PLAY: begin
          if (bp) s = S_PAUSE;
          else if (bn || rise) begin
            if (!bn && !loop_en && i == NS - 1) begin i = 0; s = S_STOP; end
            else begin i = (i + 1) % NS; s = S_GAP; m_left[d] = GAP; end
          end
        end
        S_PAUSE: begin
          if (bp) s = S_PLAY;
          else if (bn) begin i = (i + 1) % NS; s = S_GAP; m_left[d] = GAP; end
        end
        default: begin
          if (bp) s = S_STOP;
          else if (bn) begin i = (i + 1) % NS; m_left[d] = GAP; end
          else if (m_left[d] == 1) s = S_PLAY;
          else m_left[d] = m_left[d] - 1;
        end
      endcase
    end
    m_st[d]  = s;
    m_idx[d] = i;
    m_sfq[d] = sf;
    o.st   = 3'(s);
    o.idx  = 3'(i);
    o.mode = (s == S_PLAY || s == S_PAUSE) ? 3'(i + 1) : 3'd0;
    o.en   = (s == S_PLAY);
  endtask

  task automatic cycle(input bit ms, bp, bn, sf, kv, input logic [15:0] kt, at);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    manual_sel = ms; btn_play = bp; btn_next = bn; song_finished = sf;
    key_valid = kv; key_tone = kt; auto_tone = at;
    model_step(0, ms, bp, bn, sf, kv, kt, at, e.l);
    model_step(1, ms, bp, bn, sf, kv, kt, at, e.s);
    q.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    obs_t r;
    r = {3'd1, 3'd0, 3'd0, 1'b0, 16'd0};
    @(negedge clk);
    rst_n = 1'b0;
    manual_sel = 0; btn_play = 0; btn_next = 0; song_finished = 0; key_valid = 0;
    #1;
    check_obs(0, r, got0);
    check_obs(1, r, got1);
    for (int d = 0; d < 2; d++) begin
      m_st[d] = S_STOP; m_idx[d] = 0; m_left[d] = 0; m_sfq[d] = 0;
    end
    e.l = r;
    e.s = r;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_obs(0, e.l, got0);
        check_obs(1, e.s, got1);
      end
    end
  end

  initial begin : driver
    bit ms = 0, sf = 0, kv = 0;
    logic [15:0] kt = 16'd523;
    do_reset();
    do_reset();
    cycle(0, 1, 0, 0, 0, 0, 262);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 262);
    repeat (8) cycle(0, 0, 0, 1, 0, 0, 262);
    repeat (8) cycle(0, 0, 0, 1, 0, 0, 330);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 330);
    cycle(0, 0, 0, 1, 0, 0, 330);
    repeat (6) cycle(0, 0, 0, 0, 0, 0, 330);
    repeat (3) cycle(0, 0, 0, 0, 1, 523, 330);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 330);
    cycle(0, 1, 0, 0, 0, 0, 330);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 330);
    cycle(0, 1, 0, 0, 0, 0, 330);
    cycle(0, 1, 1, 0, 0, 0, 330);
    cycle(0, 1, 0, 0, 0, 0, 330);
    cycle(0, 0, 1, 0, 0, 0, 330);
    cycle(0, 0, 0, 0, 0, 0, 330);
    repeat (3) cycle(1, 0, 0, 0, 0, 0, 330);
    cycle(0, 0, 0, 0, 0, 0, 330);
    cycle(0, 1, 0, 0, 0, 0, 330);
    cycle(0, 0, 0, 0, 0, 0, 330);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (ms) begin
        if ($urandom_range(0, 9) == 0) ms = 0;
      end else if ($urandom_range(0, 249) == 0) ms = 1;
      if ($urandom_range(0, 5) == 0) sf = ~sf;
      if ($urandom_range(0, 9) == 0) begin
        kv = ~kv;
        kt = 16'($urandom);
      end
      if ($urandom_range(0, 799) == 0) do_reset();
      else cycle(ms, $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                 sf, kv, kt, 16'($urandom));
    end
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
